music_seq_ctrl: RTL and testbench
=================================

Name: music_seq_ctrl

Overview:
- Sequencer for the song note ROMs.
- Steps the ROM address at a fixed beat rate and captures each note half-period value.
- Drives a square wave on the buzzer pin; the song-ROM value S (2500) and the value 0 are played as silence.
- Sits between the top-level key/game-state logic (start/stop/pause/loop) and one registered note ROM instance.

Parameters:
- ADDR_W, 9, ROM address width.
- NOTE_W, 20, width of the ROM note value (half-period in clk cycles).
- SONG_LEN, 384, number of ROM entries played; last address is SONG_LEN-1.
- BEAT_CYCLES, 12_500_000, clk cycles per ROM entry (0.25 s at 50 MHz); must be >= 4.
- REST_VAL, 2500, note value treated as a rest.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  level; sampled in IDLE, begins playback at address 0
- stop  in  1  level; aborts playback to IDLE
- pause  in  1  level; freezes playback while high
- loop_en  in  1  when high, playback wraps to address 0 after the last entry instead of finishing
- rom_addr  out  ADDR_W  address to the note ROM
- rom_note  in  NOTE_W  ROM output; registered, valid on the second rising edge after rom_addr changes
- buzzer  out  1  square-wave audio output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a non-looping song ends
- cur_note  out  NOTE_W  currently playing note value

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; rom_addr=0, buzzer=0, busy=0, done=0, cur_note=0.
  - All counters cleared.
  - Applies from any state, including mid-note.
- State FETCH is entered with rom_addr already updated. It lasts 1 cycle, then goes to LOAD.
- State LOAD: 1 cycle; cur_note <= rom_note; tone counter cleared; buzzer <= 0; goes to PLAY.
- Beat counter:
  - Starts at 0 on entry to FETCH and increments every non-paused cycle in FETCH/LOAD/PLAY.
  - Each ROM entry occupies exactly BEAT_CYCLES non-paused cycles, measured from FETCH entry to the next FETCH entry.
- State PLAY, at beat counter = BEAT_CYCLES-1:
  - If rom_addr < SONG_LEN-1: rom_addr+1, go to FETCH.
  - Else if loop_en: rom_addr=0, go to FETCH.
  - Else: go to IDLE, pulse done for 1 cycle, buzzer=0.
  - loop_en is sampled only at this edge.
- Tone generation in PLAY:
  - If cur_note is REST_VAL or < 2, buzzer is held 0.
  - Otherwise the tone counter counts 0..cur_note-1; at cur_note-1 it wraps to 0 and buzzer toggles.
  - This gives a period of 2*cur_note cycles.
  - The first toggle occurs cur_note cycles after PLAY entry.
- Pause:
  - pause high in FETCH/LOAD/PLAY enters PAUSED at the next edge. Beat counter, tone counter and rom_addr are frozen; buzzer=0.
  - pause low returns to the frozen state with counters intact. busy stays 1.
  - Tone phase restarts from the frozen tone count with buzzer=0.
- stop high in any non-IDLE state: next edge goes to IDLE, rom_addr=0, buzzer=0, cur_note=0, no done pulse.
- Priority: rst_n > stop > pause > beat expiry > start.
- start:
  - start and stop both high in IDLE: remains IDLE.
  - start held high at song end without loop: IDLE for 1 cycle with done=1, then a restart at address 0.
  - start is ignored while busy.
- Widths:
  - All counter compares are unsigned.
  - Beat counter width is clog2(BEAT_CYCLES); tone counter width is NOTE_W.
  - rom_addr never exceeds SONG_LEN-1.

Decomposition:
- Shared package music_pkg holds:
  - the note half-period constants (M1..M7 with sharps, H1..H7, HH1, HH2, D5..D7);
  - REST_VAL;
  - the default BEAT_CYCLES;
  - the controller state enum (IDLE, FETCH, LOAD, PLAY, PAUSED).
- One sub-module, tone_gen:
  - inputs: clk, rst_n, enable, clear, half_period;
  - output: buzzer;
  - contains the half-period counter and toggle.
- The controller FSM, beat counter and address counter live in the top module.

Test Plan (BEAT_CYCLES=16, SONG_LEN=4, stub ROM with 1-cycle registered read: addr0=5, addr1=2500, addr2=3, addr3=0):
- start pulse in IDLE:
  - rom_addr 0 for 16 cycles, then 1, 2, 3 at 16-cycle spacing.
  - busy=1 throughout.
  - cur_note=5 two cycles after start.
- Entry 0 (note 5): buzzer toggles every 5 cycles from PLAY entry. Entries 1 (2500) and 3 (0): buzzer stays 0 for all 16 cycles.
- loop_en=0 at end of entry 3: done=1 for exactly 1 cycle, busy=0, rom_addr=0, buzzer=0. With loop_en=1: rom_addr wraps 3->0 and no done pulse.
- pause high for 10 cycles mid entry 0:
  - buzzer=0 and rom_addr frozen during the pause.
  - Entry 0 total duration is 26 cycles.
- stop asserted during entry 2: next cycle busy=0, rom_addr=0, cur_note=0, no done pulse. start and stop high together in IDLE: stays IDLE.
- rst_n low for 1 cycle mid-PLAY: all outputs at reset values on the following cycle; a subsequent start plays from address 0.

Source files
------------

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared note half-periods, timing defaults and sequencer state type
package music_pkg;

  // Low octave half-periods in 50 MHz clk cycles (G3, A3, B3)
  localparam int D5  = 127551;
  localparam int D6  = 113636;
  localparam int D7  = 101215;

  // Middle octave (C4..B4) with sharps
  localparam int M1  = 95556;
  localparam int M1S = 90194;
  localparam int M2  = 85131;
  localparam int M2S = 80353;
  localparam int M3  = 75843;
  localparam int M4  = 71586;
  localparam int M4S = 67568;
  localparam int M5  = 63776;
  localparam int M5S = 60197;
  localparam int M6  = 56818;
  localparam int M6S = 53630;
  localparam int M7  = 50619;

  // High octave (C5..B5)
  localparam int H1  = 47778;
  localparam int H2  = 42566;
  localparam int H3  = 37922;
  localparam int H4  = 35793;
  localparam int H5  = 31888;
  localparam int H6  = 28409;
  localparam int H7  = 25309;

  // Top notes (C6, D6)
  localparam int HH1 = 23889;
  localparam int HH2 = 21283;

  // Song-ROM marker for silence
  localparam int REST_VAL = 2500;

  // 0.25 s per ROM entry at 50 MHz
  localparam int DEFAULT_BEAT_CYCLES = 12_500_000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    PAUSED
  } seq_state_t;

endpackage

// File: rtl/music_seq_ctrl_tone_gen.sv
// rtl/music_seq_ctrl_tone_gen.sv - half-period counter driving a square wave
module tone_gen #(
  parameter int NOTE_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NOTE_W-1:0] half_period,
  output logic              buzzer
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              buzzer_q, buzzer_d;

  // Count 0..half_period-1 while enabled, toggling on wrap; hold count and mute otherwise
  always_comb begin
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    if (clear) begin
      cnt_d    = '0;
      buzzer_d = 1'b0;
    end else if (enable) begin
      if (cnt_q >= half_period - NOTE_W'(1)) begin
        cnt_d    = '0;
        buzzer_d = ~buzzer_q;
      end else begin
        cnt_d = cnt_q + NOTE_W'(1);
      end
    end else begin
      buzzer_d = 1'b0;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      buzzer_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: rtl/music_seq_ctrl.sv
// rtl/music_seq_ctrl.sv - song ROM sequencer with beat timing, pause/loop and buzzer output
module music_seq_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int NOTE_W      = 20,
  parameter int SONG_LEN    = 384,
  parameter int BEAT_CYCLES = music_pkg::DEFAULT_BEAT_CYCLES,
  parameter int REST_VAL    = music_pkg::REST_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic              buzzer,
  output logic              busy,
  output logic              done,
  output logic [NOTE_W-1:0] cur_note
);

  import music_pkg::*;

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [NOTE_W-1:0] REST_NOTE = NOTE_W'(REST_VAL);

  seq_state_t        state_q, state_d;
  seq_state_t        ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tone_ok;
  logic              tone_en;
  logic              tone_clear;

  // Next-state, beat/address stepping and note capture; priority stop > pause > beat expiry > start
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    cur_note_d = cur_note_q;
    done_d     = 1'b0;
    tone_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FETCH;
          addr_d  = '0;
          beat_d  = '0;
        end
      end

      PAUSED: begin
        if (stop) begin
          state_d    = IDLE;
          addr_d     = '0;
          beat_d     = '0;
          cur_note_d = '0;
        end else if (!pause) begin
          state_d = ret_q;
        end
      end

      default: begin
        if (stop) begin
          state_d    = IDLE;
          addr_d     = '0;
          beat_d     = '0;
          cur_note_d = '0;
        end else if (pause) begin
          // The cycle that sees pause still counts toward the beat, but the
          // counter saturates so the expiry compare is never skipped
          state_d = PAUSED;
          ret_d   = state_q;
          if (beat_q != BEAT_LAST) begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (state_q == FETCH) begin
          state_d = LOAD;
          beat_d  = beat_q + BEAT_W'(1);
        end else if (state_q == LOAD) begin
          state_d    = PLAY;
          beat_d     = beat_q + BEAT_W'(1);
          cur_note_d = rom_note;
          tone_clear = 1'b1;
        end else if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          if (addr_q < ADDR_LAST) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            addr_d     = '0;
            state_d    = IDLE;
            cur_note_d = '0;
            done_d     = 1'b1;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
    endcase

    busy_d  = (state_d != IDLE);
    tone_ok = (cur_note_q != REST_NOTE) && (cur_note_q >= NOTE_W'(2));
    tone_en = (state_q == PLAY) && (state_d == PLAY) && tone_ok;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      cur_note_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      cur_note_q <= cur_note_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  tone_gen #(
    .NOTE_W(NOTE_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (tone_en),
    .clear      (tone_clear),
    .half_period(cur_note_q),
    .buzzer     (buzzer)
  );

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// tb/tb_music_seq_ctrl.sv - randomized and directed bench for music_seq_ctrl
module tb_music_seq_ctrl;

  localparam int BEAT = 16;
  localparam int LEN  = 4;
  localparam int REST = 2500;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [8:0]  rom_addr;
  logic [19:0] rom_note;
  logic        buzzer;
  logic        busy;
  logic        done;
  logic [19:0] cur_note;

  int mem [LEN];
  int n_checks = 0;
  int n_errors = 0;

  music_seq_ctrl #(
    .ADDR_W     (9),
    .NOTE_W     (20),
    .SONG_LEN   (LEN),
    .BEAT_CYCLES(BEAT),
    .REST_VAL   (REST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .loop_en (loop_en),
    .rom_addr(rom_addr),
    .rom_note(rom_note),
    .buzzer  (buzzer),
    .busy    (busy),
    .done    (done),
    .cur_note(cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered stub ROM
  always @(posedge clk) rom_note <= 20'(mem[rom_addr[1:0]]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Behavioural model: entry position in non-paused cycles, phase within the entry,
  // and tone phase as arithmetic over the current uninterrupted PLAY run
  int m_busy = 0, m_addr = 0, m_note = 0, m_done = 0;
  int m_paused = 0, m_stage = 0, m_pos = 0;
  int m_run = 0, m_t0 = 0, m_j = 0, m_tcf = 0;

  function automatic int audible(input int n);
    return (n >= 2 && n != REST) ? 1 : 0;
  endfunction

  function automatic int exp_buzzer();
    if (m_run == 0 || audible(m_note) == 0) return 0;
    return ((m_t0 + m_j) / m_note) % 2;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    if (!rst_n) begin
      m_busy = 0; m_addr = 0; m_note = 0; m_paused = 0; m_run = 0; m_stage = 0; m_pos = 0;
    end else if (m_busy == 0) begin
      if (start && !stop) begin
        m_busy = 1; m_addr = 0; m_pos = 0; m_stage = 0; m_paused = 0; m_run = 0;
      end
    end else if (stop) begin
      m_busy = 0; m_addr = 0; m_note = 0; m_paused = 0; m_run = 0;
    end else if (m_paused != 0) begin
      if (!pause) begin
        m_paused = 0;
        if (m_stage == 2) begin m_run = 1; m_t0 = m_tcf; m_j = 0; end
      end
    end else if (pause) begin
      m_paused = 1;
      m_tcf = (m_run != 0 && audible(m_note) != 0) ? (m_t0 + m_j) % m_note : 0;
      m_run = 0;
      if (m_pos < BEAT - 1) m_pos++;
    end else if (m_stage == 0) begin
      m_stage = 1; m_pos++;
    end else if (m_stage == 1) begin
      m_stage = 2; m_pos++; m_note = mem[m_addr]; m_run = 1; m_t0 = 0; m_j = 0;
    end else if (m_pos == BEAT - 1) begin
      m_pos = 0; m_run = 0; m_stage = 0;
      if (m_addr < LEN - 1) m_addr++;
      else if (loop_en) m_addr = 0;
      else begin m_busy = 0; m_addr = 0; m_note = 0; m_done = 1; end
    end else begin
      m_pos++; m_j++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_cur_note", 32'(cur_note), 32'(m_note));
    chk("m_buzzer", 32'(buzzer), 32'(exp_buzzer()));
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_buzzer"}, 32'(buzzer), 32'd0);
    chk({tag, "_note"}, 32'(cur_note), 32'd0);
  endtask

  initial begin
    mem[0] = 5; mem[1] = 2500; mem[2] = 3; mem[3] = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Full song without loop
    start = 1'b1;
    for (int s = 1; s <= 66; s++) begin
      step();
      start = 1'b0;
      if (s == 1)  chk("t1_busy", 32'(busy), 32'd1);
      if (s == 2)  chk("t1_note_load", 32'(cur_note), 32'd0);
      if (s == 3)  chk("t1_note", 32'(cur_note), 32'd5);
      if (s == 7)  chk("t1_buz7", 32'(buzzer), 32'd0);
      if (s == 8)  chk("t1_buz8", 32'(buzzer), 32'd1);
      if (s == 12) chk("t1_buz12", 32'(buzzer), 32'd1);
      if (s == 13) chk("t1_buz13", 32'(buzzer), 32'd0);
      if (s == 16) chk("t1_addr16", 32'(rom_addr), 32'd0);
      if (s == 17) chk("t1_addr17", 32'(rom_addr), 32'd1);
      if (s == 25) chk("t1_rest_buz", 32'(buzzer), 32'd0);
      if (s == 33) chk("t1_addr33", 32'(rom_addr), 32'd2);
      if (s == 37) chk("t1_buz37", 32'(buzzer), 32'd0);
      if (s == 38) chk("t1_buz38", 32'(buzzer), 32'd1);
      if (s == 49) chk("t1_addr49", 32'(rom_addr), 32'd3);
      if (s == 64) chk("t1_busy64", 32'(busy), 32'd1);
      if (s == 65) begin
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_addr_end", 32'(rom_addr), 32'd0);
      end
      if (s == 66) chk("t1_done_once", 32'(done), 32'd0);
    end

    // Looping song wraps 3 -> 0 without done
    loop_en = 1'b1;
    start = 1'b1;
    for (int s = 1; s <= 81; s++) begin
      step();
      start = 1'b0;
      if (s == 64) chk("t2_addr64", 32'(rom_addr), 32'd3);
      if (s == 65) begin
        chk("t2_addr_wrap", 32'(rom_addr), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_no_done", 32'(done), 32'd0);
      end
      if (s == 81) chk("t2_addr81", 32'(rom_addr), 32'd1);
    end
    loop_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t2_stopped", 32'(busy), 32'd0);

    // Ten-cycle pause in entry 0 stretches it to 26 cycles
    start = 1'b1;
    for (int s = 1; s <= 30; s++) begin
      step();
      start = 1'b0;
      if (s >= 6 && s <= 15) begin
        chk("t3_pause_buz", 32'(buzzer), 32'd0);
        chk("t3_pause_addr", 32'(rom_addr), 32'd0);
        chk("t3_pause_busy", 32'(busy), 32'd1);
      end
      if (s == 18) chk("t3_buz18", 32'(buzzer), 32'd0);
      if (s == 19) chk("t3_buz19", 32'(buzzer), 32'd1);
      if (s == 26) chk("t3_addr26", 32'(rom_addr), 32'd0);
      if (s == 27) chk("t3_addr27", 32'(rom_addr), 32'd1);
      if (s == 5)  pause = 1'b1;
      if (s == 15) pause = 1'b0;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Stop during entry 2, then start+stop together in IDLE
    start = 1'b1;
    for (int s = 1; s <= 37; s++) begin
      step();
      start = 1'b0;
      if (s == 36) begin
        chk("t4_note36", 32'(cur_note), 32'd3);
        stop = 1'b1;
      end
      if (s == 37) begin
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_addr", 32'(rom_addr), 32'd0);
        chk("t4_note", 32'(cur_note), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
      end
    end
    start = 1'b1;
    stop = 1'b1;
    step();
    chk("t4_both_a", 32'(busy), 32'd0);
    step();
    chk("t4_both_b", 32'(busy), 32'd0);
    start = 1'b0;
    stop = 1'b0;
    step();

    // Reset mid-PLAY, then replay from address 0
    start = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step();
      start = 1'b0;
    end
    chk("t5_buz_before", 32'(buzzer), 32'd1);
    rst_n = 1'b0;
    step();
    chk_reset_vals("t5_rst");
    rst_n = 1'b1;
    start = 1'b1;
    for (int s = 1; s <= 17; s++) begin
      step();
      start = 1'b0;
      if (s == 3)  chk("t5_note", 32'(cur_note), 32'd5);
      if (s == 16) chk("t5_addr16", 32'(rom_addr), 32'd0);
      if (s == 17) chk("t5_addr17", 32'(rom_addr), 32'd1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Randomized stimulus over fresh song contents
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < LEN; i++) begin
        case ($urandom_range(0, 7))
          0: mem[i] = 0;
          1: mem[i] = 1;
          2: mem[i] = 2;
          3: mem[i] = 3;
          4: mem[i] = 4;
          5: mem[i] = 5;
          6: mem[i] = 7;
          default: mem[i] = 2500;
        endcase
      end
      for (int c = 0; c < 2000; c++) begin
        step();
        rst_n = ($urandom_range(0, 399) != 0);
        start = ($urandom_range(0, 3) == 0);
        stop = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 11) == 0) pause = ~pause;
        if ($urandom_range(0, 39) == 0) loop_en = ~loop_en;
      end
      rst_n = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
